// File: rtl/slice_extractor.sv
// rtl/slice_extractor.sv - streams one WIDTH-bit word out as SLICE-bit chunks from a dynamic start index
// Optional build macro: SLICE_EXTRACTOR_DESCEND_EN (emit slices in descending index order)
module slice_extractor #(
  parameter int WIDTH  = 32,
  parameter int SLICE  = 8,
  parameter int NSLICE = WIDTH / SLICE,
  parameter int IDXW   = $clog2(NSLICE),
  parameter int LENW   = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [IDXW-1:0]  in_start,
  input  logic [LENW-1:0]  in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SLICE-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // NSLICE itself may not fit in IDXW bits (power-of-2 case), so the start
  // index wrap test is done one bit wider.
  localparam logic [IDXW:0]   NS_X     = (IDXW + 1)'(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);
  localparam logic [LENW-1:0] NS_LEN   = LENW'(NSLICE);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_word;
  logic [IDXW-1:0]  r_idx;
  logic [LENW-1:0]  r_rem;

  logic             w_accept;
  logic             w_out_hs;
  logic             w_last;
  logic [IDXW:0]    w_start_x;
  logic [IDXW-1:0]  w_start_mod;
  logic [LENW-1:0]  w_eff_len;
  logic [IDXW-1:0]  w_idx_next;
  logic [SLICE-1:0] w_slice;

  assign out_valid = (r_state == S_EMIT);
  assign w_last    = out_valid && (r_rem == LENW'(1));
  assign out_last  = w_last;
  assign out_idx   = r_idx;
  assign out_data  = w_slice;
  assign w_out_hs  = out_valid && out_ready;

  // Ready while idle, or on the final handshake so the next word follows with no bubble.
  assign in_ready  = (r_state == S_IDLE) || (w_out_hs && w_last);
  assign w_accept  = in_valid && in_ready;

  // Out-of-range start indices can only exceed NSLICE by less than NSLICE,
  // so one conditional subtract is a full modulo reduction.
  assign w_start_x   = {1'b0, in_start};
  assign w_start_mod = (w_start_x >= NS_X) ? IDXW'(w_start_x - NS_X) : in_start;

  // Zero requests a full word; oversize requests are clamped to a full word.
  assign w_eff_len   = ((in_len == '0) || (in_len > NS_LEN)) ? NS_LEN : in_len;

`ifdef SLICE_EXTRACTOR_DESCEND_EN
  assign w_idx_next  = (r_idx == '0) ? LAST_IDX : (r_idx - IDXW'(1));
`else
  assign w_idx_next  = (r_idx == LAST_IDX) ? '0 : (r_idx + IDXW'(1));
`endif

  // Select the slice addressed by the current index.
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_slice = r_word[i*SLICE +: SLICE];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave EMIT after the last handshake unless a new word is taken in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_out_hs && w_last && !w_accept) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Word, index and remaining-count registers; a new accept takes priority over the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_word <= in_data;
      r_idx  <= w_start_mod;
      r_rem  <= w_eff_len;
    end else if (w_out_hs) begin
      r_idx  <= w_idx_next;
      r_rem  <= r_rem - LENW'(1);
    end
  end

endmodule

// File: tb/tb_slice_extractor.sv
// tb/tb_slice_extractor.sv - randomized and directed bench for slice_extractor against a queue model
module tb_slice_extractor;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = 4;
  localparam int IDXW   = 2;
  localparam int LENW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [IDXW-1:0]  in_start;
  logic [LENW-1:0]  in_len;
  logic             out_valid;
  logic             out_ready;
  logic [SLICE-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [SLICE-1:0] d;
    logic [IDXW-1:0]  idx;
    logic             last;
  } exp_t;

  exp_t exp_q[$];

  slice_extractor #(
    .WIDTH (WIDTH),
    .SLICE (SLICE),
    .NSLICE(NSLICE),
    .IDXW  (IDXW),
    .LENW  (LENW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_start (in_start),
    .in_len   (in_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand an accepted word into the slices it must produce, in order.
  task automatic model_push(input logic [WIDTH-1:0] data, input int start, input int len);
    int n;
    int idx;
    exp_t e;
    n = (len == 0 || len > NSLICE) ? NSLICE : len;
    start = start % NSLICE;
    for (int k = 0; k < n; k++) begin
`ifdef SLICE_EXTRACTOR_DESCEND_EN
      idx = ((start - k) % NSLICE + NSLICE) % NSLICE;
`else
      idx = (start + k) % NSLICE;
`endif
      e.d    = SLICE'(data >> (idx * SLICE));
      e.idx  = IDXW'(idx);
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, advance the model.
  task automatic step(input logic iv, input logic [WIDTH-1:0] data, input int start,
                      input int len, input logic ordy);
    logic m_ready;
    logic m_hs;
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = data;
    in_start  = IDXW'(start);
    in_len    = LENW'(len);
    out_ready = ordy;
    @(negedge clk);
    m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    m_hs    = (exp_q.size() != 0) && ordy;
    check_val("out_valid", out_valid, exp_q.size() != 0);
    check_val("in_ready", in_ready, m_ready);
    if (exp_q.size() != 0) begin
      check_val("out_data", out_data, exp_q[0].d);
      check_val("out_idx", out_idx, exp_q[0].idx);
      check_val("out_last", out_last, exp_q[0].last);
    end
    if (m_hs) void'(exp_q.pop_front());
    if (iv && m_ready) model_push(data, start, len);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 0, 0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_start  = '0;
    in_len    = '0;
    out_ready = 1'b0;

    @(negedge clk);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_last", out_last, 1'b0);
    check_val("rst_out_idx", out_idx, '0);
    check_val("rst_out_data", out_data, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1'b1);

    // Full word ascending from 0.
    step(1'b1, 32'hDDCCBBAA, 0, 4, 1'b1);
    idle(5);
    // Wrap-around from start 3.
    step(1'b1, 32'hDDCCBBAA, 3, 2, 1'b1);
    idle(3);
    // Length 0 and oversize length both give a full word.
    step(1'b1, 32'hDDCCBBAA, 1, 0, 1'b1);
    idle(5);
    step(1'b1, 32'hDDCCBBAA, 2, 7, 1'b1);
    idle(5);
    // Backpressure on the second slice.
    step(1'b1, 32'hDDCCBBAA, 0, 4, 1'b1);
    step(1'b0, '0, 0, 0, 1'b1);
    step(1'b0, '0, 0, 0, 1'b0);
    step(1'b0, '0, 0, 0, 1'b0);
    step(1'b0, '0, 0, 0, 1'b0);
    idle(4);
    // Back-to-back words, plus an ignored offer mid-word.
    step(1'b1, 32'hDDCCBBAA, 0, 4, 1'b1);
    step(1'b0, '0, 0, 0, 1'b1);
    step(1'b1, 32'h99887766, 2, 1, 1'b1);
    step(1'b0, '0, 0, 0, 1'b1);
    step(1'b1, 32'h44332211, 0, 4, 1'b1);
    idle(5);
    // Last slice stalled while a new word waits: must not be taken early.
    step(1'b1, 32'hDDCCBBAA, 0, 1, 1'b1);
    step(1'b1, 32'h44332211, 1, 2, 1'b0);
    step(1'b1, 32'h44332211, 1, 2, 1'b1);
    idle(4);

    // Reset in the middle of a word.
    step(1'b1, 32'hDDCCBBAA, 0, 4, 1'b1);
    step(1'b0, '0, 0, 0, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("midrst_out_valid", out_valid, 1'b0);
    exp_q.delete();
    @(negedge clk);
    check_val("midrst_in_ready", in_ready, 1'b1);
    #1 rst = 1'b0;
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, NSLICE - 1)),
           int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
